// File: rtl/slice_scheduler.sv
// ---------------------------------------------------------------------------
// slice_scheduler
//
// Streams one angular slice of a rotating multiplexed LED display out of a
// double-buffered framebuffer RAM. Each slice is ROWS segments of 512 cycles.
// The first BLANKING_TIME cycles of every segment are blanked. RAM reads run
// one cycle ahead of the pixel output, so read data lines up with the
// output window without adding latency. Bank swaps are taken only at the
// start of a revolution, so a displayed image is never torn mid-slice.
//
// Ports
//   clk_33           in   system clock, rising edge
//   nrst             in   synchronous active-low reset
//   bank_ready       in   pulse: hidden bank has been fully written
//   position_sync    in   pulse: rotation sensor at angle 0
//   ram_rdata        in   RAM read data, valid one cycle after ram_rd_en
//   ram_rd_en        out  RAM read strobe
//   ram_addr         out  {bank_sel, slice[6:0], row[2:0], word[8:0]}
//   bank_sel         out  bank currently displayed
//   framebuffer_dat  out  pixel word to the driver controller
//   framebuffer_sync out  pulse on the cycle before a slice starts
//   row_en           out  one-hot row enable
//   slice_index      out  slice currently streamed
// ---------------------------------------------------------------------------
module slice_scheduler #(
    parameter int BLANKING_TIME = 80,
    parameter int ROWS          = 8,
    parameter int N_SLICES      = 128
) (
    input  logic            clk_33,
    input  logic            nrst,
    input  logic            bank_ready,
    input  logic            position_sync,
    input  logic [29:0]     ram_rdata,
    output logic            ram_rd_en,
    output logic [19:0]     ram_addr,
    output logic            bank_sel,
    output logic [29:0]     framebuffer_dat,
    output logic            framebuffer_sync,
    output logic [ROWS-1:0] row_en,
    output logic [6:0]      slice_index
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

    localparam logic [8:0] SEG_LAST  = 9'd511;
    localparam logic [8:0] RD_FIRST  = 9'(BLANKING_TIME - 1);
    localparam logic [8:0] RD_LAST   = 9'd510;
    localparam logic [8:0] DAT_FIRST = 9'(BLANKING_TIME);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [SW-1:0] SLICE_LAST = SW'(N_SLICES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_POS = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t          r_state;
    logic [8:0]      r_seg;
    logic [RW-1:0]   r_row;
    logic [SW-1:0]   r_slice;
    logic            r_bank;
    logic            r_pending;
    logic            r_pos_latch;
    logic [ROWS-1:0] r_row_en;

    logic            w_run;
    logic            w_seg_wrap;
    logic            w_row_last;
    logic            w_slice_end;
    logic            w_to_zero;
    logic [RW-1:0]   w_row_next;
    logic            w_rd_en;
    logic [8:0]      w_word;

    assign w_run       = (r_state == RUN);
    assign w_seg_wrap  = (r_seg == SEG_LAST);
    assign w_row_last  = (r_row == ROW_LAST);
    assign w_slice_end = w_run && w_seg_wrap && w_row_last;
    assign w_row_next  = w_row_last ? '0 : r_row + RW'(1);

    // A pending position pulse (latched earlier or arriving on this very
    // boundary) restarts the revolution; both it and the natural wrap count
    // as "revolution start" for the bank swap check.
    assign w_to_zero   = r_pos_latch || position_sync || (r_slice == SLICE_LAST);

    always_ff @(posedge clk_33) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_seg       <= '0;
            r_row       <= '0;
            r_slice     <= '0;
            r_bank      <= 1'b0;
            r_pending   <= 1'b0;
            r_pos_latch <= 1'b0;
            r_row_en    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bank_ready) begin
                        r_state <= WAIT_POS;
                        r_bank  <= ~r_bank;
                    end
                end
                WAIT_POS: begin
                    if (bank_ready) begin
                        r_pending <= 1'b1;
                    end
                    if (position_sync) begin
                        r_state     <= RUN;
                        r_seg       <= '0;
                        r_row       <= '0;
                        r_slice     <= '0;
                        r_pos_latch <= 1'b0;
                        r_row_en    <= ROWS'(1);
                    end
                end
                RUN: begin
                    r_seg <= r_seg + 9'd1;
                    if (w_seg_wrap) begin
                        r_row    <= w_row_next;
                        r_row_en <= ROWS'(1) << w_row_next;
                    end
                    if (w_slice_end) begin
                        r_slice     <= w_to_zero ? '0 : r_slice + SW'(1);
                        r_pos_latch <= 1'b0;
                        // Swap consumes the old pending flag; a bank_ready
                        // on the same cycle re-arms it for the next swap.
                        if (w_to_zero && r_pending) begin
                            r_bank <= ~r_bank;
                        end
                        r_pending <= bank_ready || (r_pending && !w_to_zero);
                    end else begin
                        if (bank_ready) begin
                            r_pending <= 1'b1;
                        end
                        if (position_sync) begin
                            r_pos_latch <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Reads lead the pixel window by one cycle to absorb the RAM latency.
    assign w_rd_en = w_run && (r_seg >= RD_FIRST) && (r_seg <= RD_LAST);
    assign w_word  = w_rd_en ? (r_seg - RD_FIRST) : '0;

    assign ram_rd_en        = w_rd_en;
    assign ram_addr         = {r_bank, 7'(r_slice), 3'(r_row), w_word};
    assign bank_sel         = r_bank;
    assign framebuffer_dat  = (w_run && (r_seg >= DAT_FIRST)) ? ram_rdata : '0;
    assign framebuffer_sync = ((r_state == WAIT_POS) && position_sync) || w_slice_end;
    assign row_en           = r_row_en;
    assign slice_index      = 7'(r_slice);

endmodule

// File: tb/tb_slice_scheduler.sv
// ---------------------------------------------------------------------------
// tb_slice_scheduler
//
// Self-checking bench for slice_scheduler. A behavioural model tracks the
// position inside a slice as one flat cycle count and derives seg/row with
// division; every cycle all outputs are compared against it. A start-up
// vector table and directed sequences cover the corner cases. The DUT uses
// a short revolution (8 slices) so revolution wraps happen in bounded time.
// ---------------------------------------------------------------------------
module tb_slice_scheduler;

    localparam int BT        = 80;
    localparam int ROWS      = 8;
    localparam int NS        = 8;
    localparam int SLICE_LEN = ROWS * 512;

    logic        clk_33 = 1'b0;
    logic        nrst = 1'b0;
    logic        bank_ready = 1'b0;
    logic        position_sync = 1'b0;
    logic [29:0] ram_rdata = '0;
    logic        ram_rd_en;
    logic [19:0] ram_addr;
    logic        bank_sel;
    logic [29:0] framebuffer_dat;
    logic        framebuffer_sync;
    logic [7:0]  row_en;
    logic [6:0]  slice_index;

    slice_scheduler #(
        .BLANKING_TIME(BT),
        .ROWS(ROWS),
        .N_SLICES(NS)
    ) dut (
        .clk_33(clk_33),
        .nrst(nrst),
        .bank_ready(bank_ready),
        .position_sync(position_sync),
        .ram_rdata(ram_rdata),
        .ram_rd_en(ram_rd_en),
        .ram_addr(ram_addr),
        .bank_sel(bank_sel),
        .framebuffer_dat(framebuffer_dat),
        .framebuffer_sync(framebuffer_sync),
        .row_en(row_en),
        .slice_index(slice_index)
    );

    always #5 clk_33 = ~clk_33;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 0;

    // Reference model state.
    bit          m_run, m_arm, m_bank, m_pend, m_pos;
    int          m_c, m_slice;
    bit          m_prev_rd;
    logic [19:0] m_prev_addr;

    // Snapshot of DUT outputs from the most recent tick.
    logic        s_rd, s_bank, s_sync;
    logic [19:0] s_addr;
    logic [29:0] s_dat;
    logic [7:0]  s_rowen;
    logic [6:0]  s_slice;

    typedef struct {
        bit          rst_n;
        bit          br;
        bit          ps;
        bit          e_bank;
        bit          e_sync;
        logic [7:0]  e_rowen;
        bit          e_rd;
        logic [19:0] e_addr;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [29:0] pattern(input logic [19:0] a);
        logic [9:0] lo;
        lo = a[9:0];
        return {lo ^ 10'h2AB, a};
    endfunction

    // One clock cycle: drive inputs, compare against the model, then advance.
    task automatic tick(input bit rst_n, input bit br, input bit ps);
        int seg, row, word, a;
        bit e_rd, e_sync, nz, sw;
        logic [19:0] e_addr;
        logic [29:0] e_dat;
        logic [7:0]  e_rowen;
        nrst = rst_n;
        bank_ready = br;
        position_sync = ps;
        ram_rdata = m_prev_rd ? pattern(m_prev_addr) : (30'($urandom) | 30'd1);
        seg     = m_c % 512;
        row     = m_c / 512;
        e_rd    = m_run && seg >= BT - 1 && seg <= 510;
        word    = e_rd ? seg - (BT - 1) : 0;
        a       = (int'(m_bank) << 19) | (m_slice << 12) | (row << 9) | word;
        e_addr  = 20'(a);
        e_dat   = (m_run && seg >= BT) ? ram_rdata : 30'd0;
        e_sync  = (m_arm && ps) || (m_run && m_c == SLICE_LEN - 1);
        e_rowen = m_run ? (8'd1 << row) : 8'd0;
        #2;
        s_rd = ram_rd_en; s_addr = ram_addr; s_bank = bank_sel; s_dat = framebuffer_dat;
        s_sync = framebuffer_sync; s_rowen = row_en; s_slice = slice_index;
        if (chk_en) begin
            chk("ram_rd_en", 32'(s_rd), 32'(e_rd));
            chk("ram_addr", 32'(s_addr), 32'(e_addr));
            chk("bank_sel", 32'(s_bank), 32'(m_bank));
            chk("framebuffer_dat", 32'(s_dat), 32'(e_dat));
            chk("framebuffer_sync", 32'(s_sync), 32'(e_sync));
            chk("row_en", 32'(s_rowen), 32'(e_rowen));
            chk("slice_index", 32'(s_slice), 32'(m_slice));
        end
        @(posedge clk_33);
        m_prev_rd = e_rd;
        m_prev_addr = e_addr;
        if (!rst_n) begin
            m_run = 0; m_arm = 0; m_bank = 0; m_pend = 0; m_pos = 0;
            m_c = 0; m_slice = 0; m_prev_rd = 0;
        end else if (m_run) begin
            if (m_c == SLICE_LEN - 1) begin
                nz = m_pos || ps || (m_slice == NS - 1);
                sw = nz && m_pend;
                if (sw) m_bank = !m_bank;
                m_pend  = br || (m_pend && !sw);
                m_slice = nz ? 0 : m_slice + 1;
                m_pos   = 0;
                m_c     = 0;
            end else begin
                m_c++;
                if (br) m_pend = 1;
                if (ps) m_pos = 1;
            end
        end else if (m_arm) begin
            if (br) m_pend = 1;
            if (ps) begin
                m_arm = 0; m_run = 1; m_c = 0; m_slice = 0; m_pos = 0;
            end
        end else if (br) begin
            m_arm = 1;
            m_bank = !m_bank;
        end
        cyc++;
        @(negedge clk_33);
    endtask

    // Advance until the next sampled cycle is (slice s, position c).
    task automatic goto(input int s, input int c);
        int n = 0;
        while (!(m_run && m_slice == s && m_c == c) && n < 40000) begin
            tick(1, 0, 0);
            n++;
        end
        chk("goto_bound", 32'(n < 40000), 32'd1);
    endtask

    initial begin
        m_run = 0; m_arm = 0; m_bank = 0; m_pend = 0; m_pos = 0;
        m_c = 0; m_slice = 0; m_prev_rd = 0; m_prev_addr = '0;

        //          rst br ps  bank sync rowen  rd  addr
        vt[0] = '{0, 0, 0,  0,  0, 8'h00, 0, 20'h00000};
        vt[1] = '{1, 0, 1,  0,  0, 8'h00, 0, 20'h00000};
        vt[2] = '{1, 1, 0,  0,  0, 8'h00, 0, 20'h00000};
        vt[3] = '{1, 0, 0,  1,  0, 8'h00, 0, 20'h80000};
        vt[4] = '{1, 1, 0,  1,  0, 8'h00, 0, 20'h80000};
        vt[5] = '{1, 0, 1,  1,  1, 8'h00, 0, 20'h80000};
        vt[6] = '{1, 0, 0,  1,  0, 8'h01, 0, 20'h80000};

        // Power-on: outputs unknown until the first reset edge.
        tick(0, 0, 0);
        chk_en = 1;

        for (int i = 0; i < 7; i++) begin
            tick(vt[i].rst_n, vt[i].br, vt[i].ps);
            chk("vec_bank", 32'(s_bank), 32'(vt[i].e_bank));
            chk("vec_sync", 32'(s_sync), 32'(vt[i].e_sync));
            chk("vec_rowen", 32'(s_rowen), 32'(vt[i].e_rowen));
            chk("vec_rd", 32'(s_rd), 32'(vt[i].e_rd));
            chk("vec_addr", 32'(s_addr), 32'(vt[i].e_addr));
        end

        // First slice in full: read window, pixel window, rows, sync, index.
        for (int k = 1; k <= 4096; k++) begin
            tick(1, 0, 0);
            if (k == 78) chk("rd_before_window", 32'(s_rd), 32'd0);
            if (k == 79) begin
                chk("rd_first", 32'(s_rd), 32'd1);
                chk("addr_first", 32'(s_addr), 32'h80000);
            end
            if (k == 510) chk("addr_last_word", 32'(s_addr), 32'h80000 + 32'd431);
            if (k == 511) chk("rd_after_window", 32'(s_rd), 32'd0);
            if (k < 512) chk("fb_nonzero_window", 32'(s_dat != 30'd0), 32'(k >= 80));
            if (k % 512 == 0 && k < 4096) chk("row_order", 32'(s_rowen), 32'd1 << (k / 512));
            if (k == 4094) chk("sync_early", 32'(s_sync), 32'd0);
            if (k == 4095) chk("sync_4095", 32'(s_sync), 32'd1);
            if (k == 4096) begin
                chk("slice_0_to_1", 32'(s_slice), 32'd1);
                chk("row_wrap", 32'(s_rowen), 32'h01);
            end
        end

        // position_sync mid-slice 5 restarts at slice 0; pending swap taken.
        goto(5, 200);
        tick(1, 0, 1);
        chk("pos_at_slice5", 32'(s_slice), 32'd5);
        goto(5, 4095);
        tick(1, 0, 0);
        chk("bank_before_pos_wrap", 32'(s_bank), 32'd1);
        tick(1, 0, 0);
        chk("pos_slice_zero", 32'(s_slice), 32'd0);
        chk("pos_swap_bank", 32'(s_bank), 32'd0);

        // bank_ready at slice 5 waits for the revolution wrap; a second
        // bank_ready on the wrap cycle stays pending.
        goto(5, 10);
        tick(1, 1, 0);
        goto(6, 0);
        tick(1, 0, 0);
        chk("bank_hold_slice6", 32'(s_bank), 32'd0);
        goto(7, 4095);
        tick(1, 1, 0);
        chk("bank_hold_last", 32'(s_bank), 32'd0);
        chk("slice_last", 32'(s_slice), 32'd7);
        tick(1, 0, 0);
        chk("wrap_slice", 32'(s_slice), 32'd0);
        chk("wrap_swap", 32'(s_bank), 32'd1);

        goto(0, 50);
        tick(1, 0, 1);
        goto(0, 4095);
        tick(1, 0, 0);
        chk("coincide_hold", 32'(s_bank), 32'd1);
        tick(1, 0, 0);
        chk("coincide_pending_swap", 32'(s_bank), 32'd0);
        chk("coincide_slice", 32'(s_slice), 32'd0);

        // position_sync exactly on the boundary applies to that boundary.
        goto(0, 4095);
        tick(1, 0, 1);
        tick(1, 0, 0);
        chk("pos_on_boundary", 32'(s_slice), 32'd0);
        chk("no_pending_no_swap", 32'(s_bank), 32'd0);

        // Reset mid-segment at row 3, seg 300.
        goto(0, 3 * 512 + 300);
        tick(0, 0, 0);
        tick(1, 0, 1);
        chk("rst_rowen", 32'(s_rowen), 32'd0);
        chk("rst_rd", 32'(s_rd), 32'd0);
        chk("rst_addr", 32'(s_addr), 32'd0);
        chk("rst_dat", 32'(s_dat), 32'd0);
        chk("rst_sync_ignored_ps", 32'(s_sync), 32'd0);
        tick(1, 0, 0);
        chk("idle_after_ps", 32'(s_rowen), 32'd0);

        // Random pulses and occasional resets against the model.
        for (int i = 0; i < 8000; i++) begin
            tick(($urandom % 5000) != 0, ($urandom % 600) == 0, ($urandom % 700) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/slice_scheduler.md
SLICE_SCHEDULER -- requirements
Module: slice_scheduler

Interface
REQ-001 SHALL have parameter BLANKING_TIME, default 80, meaning blanking cycles at the start of each 512-cycle segment.
REQ-002 SHALL have parameter ROWS, default 8, meaning multiplexed rows (segments) per slice, power of two.
REQ-003 SHALL have parameter N_SLICES, default 128, meaning slices per revolution, power of two.
REQ-004 SHALL have port clk_33  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port nrst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port bank_ready  in  1  one-cycle pulse: writer finished filling the bank not being displayed.
REQ-007 SHALL have port position_sync  in  1  one-cycle pulse from the rotation sensor marking angle 0.
REQ-008 SHALL have port ram_rdata  in  30  framebuffer RAM read data, valid exactly 1 cycle after ram_rd_en.
REQ-009 SHALL have port ram_rd_en  out  1  RAM read strobe.
REQ-010 SHALL have port ram_addr  out  20  {bank_sel, slice[6:0], row[2:0], word[8:0]}.
REQ-011 SHALL have port bank_sel  out  1  bank currently displayed.
REQ-012 SHALL have port framebuffer_dat  out  30  pixel word to driver controller.
REQ-013 SHALL have port framebuffer_sync  out  1  one-cycle pulse preceding the first cycle of each slice.
REQ-014 SHALL have port row_en  out  ROWS  one-hot row-enable for the multiplexing transistors.
REQ-015 SHALL have port slice_index  out  7  slice currently streamed.

Function
REQ-016 SHALL implement states IDLE, WAIT_POS and RUN; IDLE -> WAIT_POS on bank_ready; WAIT_POS -> RUN on position_sync; RUN is left only by reset.
REQ-017 SHALL, on the IDLE -> WAIT_POS transition, toggle bank_sel so the freshly written bank is displayed.
REQ-018 SHALL run, in RUN, a segment counter seg 0..511 wrapping to 0, and a row counter incremented when seg wraps, from 0..ROWS-1.
REQ-019 SHALL increment slice_index when row and seg wrap together, modulo N_SLICES.
REQ-020 SHALL assert ram_rd_en for seg in [BLANKING_TIME-1, 510] with word = seg - (BLANKING_TIME-1), giving words 0..431.
REQ-021 SHALL drive framebuffer_dat = ram_rdata for seg in [BLANKING_TIME, 511] and 30'h0 otherwise, with zero added latency.
REQ-022 SHALL pulse framebuffer_sync on the WAIT_POS -> RUN cycle and on every cycle where seg = 511 and row = ROWS-1; the next cycle is seg 0, row 0.
REQ-023 SHALL drive row_en one-hot at bit row while in RUN, changing only on the cycle seg becomes 0, and all-zero outside RUN.
REQ-024 SHALL latch bank_ready in a sticky pending flag; at slice wrap N_SLICES-1 -> 0 with pending set it SHALL toggle bank_sel and clear pending in the same cycle.
REQ-025 SHALL, when bank_ready and a swap coincide, swap and leave pending set.
REQ-026 SHALL latch position_sync in RUN; at the next slice boundary slice_index SHALL become 0, not slice+1, with the bank swap check applied; the latch clears.
REQ-027 SHALL treat position_sync on the exact slice-boundary cycle as applying to that boundary.
REQ-028 SHALL never change bank_sel mid-slice; ram_addr bank bit always equals bank_sel.
REQ-029 SHALL ignore position_sync in IDLE and bank_ready in WAIT_POS except for setting pending.

Reset
REQ-030 SHALL on nrst=0 force state IDLE, seg/row/slice 0, bank_sel 0, pending and position latch 0, ram_rd_en 0, ram_addr 0, framebuffer_dat 0, framebuffer_sync 0, row_en 0.
REQ-031 SHALL accept reset at any cycle including mid-segment, with all outputs at reset values on the following cycle.

Verification
REQ-032 SHALL cover: reset, bank_ready, position_sync -> bank_sel=1, sync pulse, first ram_rd_en at seg 79 with addr {1,0,0,0}, framebuffer_dat non-zero only seg 80..511.
REQ-033 SHALL cover: free run 8x512 cycles -> row_en 0x01..0x80 in order, sync at cycle 4095, slice_index 0 -> 1.
REQ-034 SHALL cover: bank_ready at slice 5 -> bank_sel unchanged until slice 127 -> 0 wrap, then toggles.
REQ-035 SHALL cover: position_sync at slice 40, seg 200 -> next slice_index 0, not 41.
REQ-036 SHALL cover: nrst low at row 3 seg 300 -> outputs zero next cycle, state IDLE, further position_sync ignored.
